cache_sys_responder: RTL and testbench

//  Cache-side end of the CPU<->cache clock-crossing bridge. Consumes the one-cycle rd/wr strobes

---
 rtl/cache_resp_pkg.sv | 41 ++++
 rtl/cache_req_queue.sv | 55 +++++
 rtl/cache_sys_responder.sv | 154 +++++++++++++++
 tb/tb_cache_sys_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_resp_pkg.sv
`default_nettype none
// ============================================================================
// Package : cache_resp_pkg
// FSM state encoding and request-entry layout shared by the cache responder.
// Rev     : 1.0
// ============================================================================
package cache_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

  // Entry layout, MSB first: {rd, wr, bval, addr, wdata}; matches the bridge TX packet.
  function automatic int entry_width(input int aw, input int ww, input int bw);
    return aw + ww + bw + 2;
  endfunction

  function automatic int off_wdata();
    return 0;
  endfunction

  function automatic int off_addr(input int ww);
    return ww;
  endfunction

  function automatic int off_bval(input int aw, input int ww);
    return ww + aw;
  endfunction

  function automatic int off_wr(input int aw, input int ww, input int bw);
    return ww + aw + bw;
  endfunction

  function automatic int off_rd(input int aw, input int ww, input int bw);
    return ww + aw + bw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_req_queue.sv
`default_nettype none
// ============================================================================
// Module : cache_req_queue
// Synchronous FIFO with registered count and first-word-fall-through head.
// Rev    : 1.0
// ============================================================================
module cache_req_queue #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_PW = $clog2(DEPTH);
  localparam logic [c_PW:0] c_FULL = (c_PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [c_PW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
      r_count <= r_count + (c_PW + 1)'(w_push) - (c_PW + 1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/cache_sys_responder.sv
`default_nettype none
// ============================================================================
// Module : cache_sys_responder
// Cache-side bridge endpoint: queues rd/wr strobes, serves them from a local
// byte-lane SRAM after RSP_LAT cycles and returns one-cycle ack/rdata pushes.
// Rev    : 1.0
// ============================================================================
module cache_sys_responder
  import cache_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32,
  parameter int BVAL_WIDTH = 4,
  parameter int MEM_AW     = 10,
  parameter int RSP_LAT    = 2,
  parameter int REQ_DEPTH  = 4
) (
  input  logic                  cache_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cache_sys_addr,
  input  logic [WORD_WIDTH-1:0] cache_sys_wdata,
  input  logic [BVAL_WIDTH-1:0] cache_sys_bval,
  input  logic                  cache_sys_rd,
  input  logic                  cache_sys_wr,
  output logic [WORD_WIDTH-1:0] cache_sys_rdata,
  output logic                  cache_sys_ack,
  output logic                  tx_fifo_ctrl,
  output logic                  req_overflow,
  output logic                  busy
);

  localparam int c_ENT_W    = entry_width(ADDR_WIDTH, WORD_WIDTH, BVAL_WIDTH);
  localparam int c_OFF_WD   = off_wdata();
  localparam int c_OFF_ADDR = off_addr(WORD_WIDTH);
  localparam int c_OFF_BVAL = off_bval(ADDR_WIDTH, WORD_WIDTH);
  localparam int c_OFF_WR   = off_wr(ADDR_WIDTH, WORD_WIDTH, BVAL_WIDTH);
  localparam int c_OFF_RD   = off_rd(ADDR_WIDTH, WORD_WIDTH, BVAL_WIDTH);
  localparam int c_CW       = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;
  localparam logic [c_CW-1:0] c_LAT_M1 = c_CW'(RSP_LAT - 1);

  resp_state_e           r_state;
  logic [c_CW-1:0]       r_cnt;
  logic                  r_rd;
  logic                  r_wr;
  logic [BVAL_WIDTH-1:0] r_bval;
  logic [MEM_AW-1:0]     r_idx;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic                  r_tx;
  logic                  r_ack;
  logic [WORD_WIDTH-1:0] r_rdata;
  logic                  r_ovf;
  logic [WORD_WIDTH-1:0] r_sram [2**MEM_AW];

  logic                  w_strobe;
  logic [c_ENT_W-1:0]    w_entry;
  logic [c_ENT_W-1:0]    w_head;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_access;
  logic [WORD_WIDTH-1:0] w_old;
  logic [WORD_WIDTH-1:0] w_merged;
  logic                  w_unused;

  assign w_strobe = cache_sys_rd | cache_sys_wr;
  assign w_entry  = {cache_sys_rd, cache_sys_wr, cache_sys_bval, cache_sys_addr, cache_sys_wdata};
  assign w_pop    = ~w_empty & ((r_state == ST_IDLE) | (r_state == ST_RESP));
  assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);

  cache_req_queue #(
    .WIDTH (c_ENT_W),
    .DEPTH (REQ_DEPTH)
  ) u_queue (
    .clk     (cache_clk),
    .rst_n   (rst_n),
    .i_push  (w_strobe),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Only the word index is decoded; the rest of the byte address aliases.
  assign w_head_addr = w_head[c_OFF_ADDR +: ADDR_WIDTH];
  assign w_unused    = ^{w_head_addr[ADDR_WIDTH-1:MEM_AW+2], w_head_addr[1:0]};

  assign w_old = r_sram[r_idx];

  // Write-merged word doubles as read data, giving write-before-read for rd&wr.
  for (genvar g = 0; g < BVAL_WIDTH; g++) begin : g_lane
    assign w_merged[8*g +: 8] = (r_wr && r_bval[g]) ? r_wdata[8*g +: 8] : w_old[8*g +: 8];
  end

  always_ff @(posedge cache_clk) begin
    if (w_access && r_wr) r_sram[r_idx] <= w_merged;
  end

  always_ff @(posedge cache_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_bval  <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_tx    <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_tx  <= 1'b0;
      r_ack <= 1'b0;
      r_ovf <= r_ovf | (w_strobe & w_full);
      if (w_pop) begin
        r_cnt   <= c_LAT_M1;
        r_rd    <= w_head[c_OFF_RD];
        r_wr    <= w_head[c_OFF_WR];
        r_bval  <= w_head[c_OFF_BVAL +: BVAL_WIDTH];
        r_idx   <= w_head_addr[MEM_AW+1:2];
        r_wdata <= w_head[c_OFF_WD +: WORD_WIDTH];
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RESP;
            r_tx    <= 1'b1;
            r_ack   <= 1'b1;
            r_rdata <= r_rd ? w_merged : '0;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        ST_RESP: begin
          r_state <= w_empty ? ST_IDLE : ST_WAIT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cache_sys_rdata = r_rdata;
  assign cache_sys_ack   = r_ack;
  assign tx_fifo_ctrl    = r_tx;
  assign req_overflow    = r_ovf;
  assign busy            = ~w_empty | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_sys_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_sys_responder
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level timing and memory model.
// Rev    : 1.0
// ============================================================================
module tb_cache_sys_responder;

  localparam int L     = 2;
  localparam int DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bval;
  logic        rd;
  logic        wr;
  logic [31:0] rdata;
  logic        ack;
  logic        tx;
  logic        ovf;
  logic        busy;

  cache_sys_responder #(
    .ADDR_WIDTH (16),
    .WORD_WIDTH (32),
    .BVAL_WIDTH (4),
    .MEM_AW     (10),
    .RSP_LAT    (L),
    .REQ_DEPTH  (DEPTH)
  ) dut (
    .cache_clk       (clk),
    .rst_n           (rst_n),
    .cache_sys_addr  (addr),
    .cache_sys_wdata (wdata),
    .cache_sys_bval  (bval),
    .cache_sys_rd    (rd),
    .cache_sys_wr    (wr),
    .cache_sys_rdata (rdata),
    .cache_sys_ack   (ack),
    .tx_fifo_ctrl    (tx),
    .req_overflow    (ovf),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted request is served at
  // max(strobe+L+2, previous response+L+1) and leaves the queue L+1 cycles earlier.
  typedef struct {
    int          resp;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [1024];
  logic [31:0] last_rdata = '0;
  logic        ovf_m = 1'b0;
  int          last_resp = -1000;
  int          pulse_cyc[$];
  logic [31:0] pulse_data[$];

  always @(negedge clk) begin : mon
    bit          due;
    int          cnt;
    int          idx;
    int          rsp;
    logic [31:0] new_w;
    exp_t        e;
    if (!rst_n) begin
      exp_q.delete();
      last_rdata = '0;
      ovf_m      = 1'b0;
      last_resp  = -1000;
    end else begin
      due = (exp_q.size() != 0) && (exp_q[0].resp == cyc);
      check("tx_fifo_ctrl", tx, 32'(due));
      check("ack", ack, 32'(due));
      check("busy", busy, 32'(exp_q.size() != 0));
      check("req_overflow", ovf, 32'(ovf_m));
      if (due) begin
        check("rdata_resp", rdata, exp_q[0].data);
        last_rdata = exp_q[0].data;
        pulse_cyc.push_back(cyc);
        pulse_data.push_back(rdata);
        void'(exp_q.pop_front());
      end else begin
        check("rdata_hold", rdata, last_rdata);
      end
      if (rd || wr) begin
        cnt = 0;
        foreach (exp_q[j]) if (exp_q[j].resp - L - 1 >= cyc) cnt++;
        if (cnt >= DEPTH) begin
          ovf_m = 1'b1;
        end else begin
          rsp   = (cyc + L + 2 > last_resp + L + 1) ? cyc + L + 2 : last_resp + L + 1;
          idx   = int'(addr[11:2]);
          new_w = mem_m[idx];
          if (wr) for (int b = 0; b < 4; b++) if (bval[b]) new_w[8*b +: 8] = wdata[8*b +: 8];
          mem_m[idx] = new_w;
          e.resp     = rsp;
          e.data     = rd ? new_w : 32'h0;
          exp_q.push_back(e);
          last_resp  = rsp;
        end
      end
    end
  end

  task automatic send(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int k);
    @(posedge clk);
    #1;
    rd = r; wr = w; addr = a; wdata = d; bval = b;
    k = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k;
    int          k0;
    int          np;
    int          op;
    logic [9:0]  idx_set [8];
    logic [15:0] a;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; bval = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    idle(2);

    send(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, k);
    send(1, 0, 16'h0010, 32'h0, 4'h0, k);
    idle(1);
    drain();
    np = pulse_data.size();
    check("wr_resp_rdata", pulse_data[np-2], 32'h0);
    check("rd_resp_rdata", pulse_data[np-1], 32'hDEADBEEF);

    send(0, 1, 16'h0020, 32'h11223344, 4'hF, k);
    send(0, 1, 16'h0020, 32'hAABBCCDD, 4'h5, k);
    send(1, 0, 16'h0020, 32'h0, 4'h0, k);
    idle(1);
    drain();
    check("byte_lanes", pulse_data[pulse_data.size()-1], 32'h11BB33DD);

    send(1, 0, 16'h0010, 32'h0, 4'h0, k);
    idle(1);
    drain();
    check("latency_single", pulse_cyc[pulse_cyc.size()-1], k + 4);

    send(1, 0, 16'h0010, 32'h0, 4'h0, k0);
    repeat (3) send(1, 0, 16'h0010, 32'h0, 4'h0, k);
    idle(1);
    drain();
    np = pulse_cyc.size();
    for (int i = 0; i < 4; i++) check("latency_b2b", pulse_cyc[np-4+i], k0 + 4 + 3*i);

    // Eight back-to-back strobes: two are dropped at strobe offsets 6 and 7.
    np = pulse_cyc.size();
    repeat (8) send(1, 0, 16'h0010, 32'h0, 4'h0, k);
    idle(1);
    drain();
    check("ovf_resp_count", pulse_cyc.size() - np, 6);
    check("ovf_flag", ovf, 1);
    idle(10);
    check("ovf_sticky", ovf, 1);

    send(1, 1, 16'h1010, 32'h0000CAFE, 4'h3, k);
    send(1, 0, 16'h0010, 32'h0, 4'h0, k);
    idle(1);
    drain();
    np = pulse_data.size();
    check("alias_rdwr", pulse_data[np-2], 32'hDEADCAFE);
    check("alias_readback", pulse_data[np-1], 32'hDEADCAFE);

    send(1, 0, 16'h0020, 32'h0, 4'h0, k);
    @(posedge clk);
    #1;
    rd = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 0);
    check("midrst_ack", ack, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf, 0);
    np = pulse_cyc.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    check("midrst_no_pulse", pulse_cyc.size() - np, 0);
    send(1, 0, 16'h0020, 32'h0, 4'h0, k);
    idle(1);
    drain();
    check("post_rst_read", pulse_data[pulse_data.size()-1], 32'h11BB33DD);

    for (int i = 0; i < 8; i++) begin
      idx_set[i] = 10'($urandom_range(0, 1023));
      send(0, 1, {4'h0, idx_set[i], 2'b00}, $urandom, 4'hF, k);
    end
    idle(1);
    drain();
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 2);
      a  = {4'($urandom_range(0, 15)), idx_set[$urandom_range(0, 7)], 2'($urandom_range(0, 3))};
      send(op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)), k);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
